// File: rtl/uart_pkg.sv
// Shared constants, FSM states and helpers for the multi-requester UART transmit path.
package uart_pkg;

  localparam int CLKS_PER_BIT   = 868;
  localparam int BITS_PER_FRAME = 10;
  localparam int MAX_BYTES      = 8;
  localparam int NUM_REQ        = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } state_e;

  // Byte counts above MAX_BYTES are sent as a full 8-byte message.
  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    return (l > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : l;
  endfunction

endpackage

// File: rtl/uart_8bytes_tx.sv
// Serialises up to eight bytes, low byte first, as 8N1 frames (start 0, LSB-first data, stop 1).
module uart_8bytes_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bytes2send,
  input  logic [3:0]  bytes_num,
  input  logic        pulse,
  output logic        tx
);
  import uart_pkg::*;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [63:0]   data_q;
  logic [3:0]    bytes_left_q;
  logic [3:0]    bit_idx_q;
  logic [CW-1:0] clk_cnt_q;
  logic          active_q;
  logic          tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q       <= '0;
      bytes_left_q <= '0;
      bit_idx_q    <= '0;
      clk_cnt_q    <= '0;
      active_q     <= 1'b0;
      tx_q         <= 1'b1;
    end else if (!active_q) begin
      if (pulse && bytes_num != 4'd0) begin
        data_q       <= bytes2send;
        bytes_left_q <= bytes_num;
        bit_idx_q    <= '0;
        clk_cnt_q    <= '0;
        active_q     <= 1'b1;
        tx_q         <= 1'b0;
      end
    end else if (clk_cnt_q != CW'(CLKS_PER_BIT - 1)) begin
      clk_cnt_q <= clk_cnt_q + 1'b1;
    end else begin
      clk_cnt_q <= '0;
      // bit_idx 0 is the start bit, 1..8 data, 9 the stop bit.
      if (bit_idx_q == 4'(BITS_PER_FRAME - 1)) begin
        if (bytes_left_q == 4'd1) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          data_q       <= data_q >> 8;
          bytes_left_q <= bytes_left_q - 1'b1;
          bit_idx_q    <= '0;
          tx_q         <= 1'b0;
        end
      end else begin
        bit_idx_q <= bit_idx_q + 1'b1;
        tx_q      <= (bit_idx_q == 4'd8) ? 1'b1 : data_q[bit_idx_q[2:0]];
      end
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one of four requesters the shared UART transmitter;
// message timing is derived purely from its own counters.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_BITS     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [255:0] msg,
  input  logic [15:0]  len,
  output logic [3:0]   ack,
  output logic         done,
  output logic         busy,
  output logic         tx
);
  import uart_pkg::*;

  localparam int IDX_W      = $clog2(NUM_REQ);
  localparam int MSG_W      = 8 * MAX_BYTES;
  localparam int SEND_W     = $clog2(MAX_BYTES * BITS_PER_FRAME * CLKS_PER_BIT + 1);
  localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e             state_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic               armed_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               done_q;
  logic               pulse_q;
  logic [MSG_W-1:0]   msg_q;
  logic [3:0]         len_q;
  logic [SEND_W-1:0]  send_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;

  logic               grant_vld_d;
  logic [IDX_W-1:0]   grant_idx_d;
  logic [IDX_W-1:0]   cand_d;
  logic [SEND_W-1:0]  send_last;

  // Scan downward so the requester nearest after last_grant is the one left standing.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
    cand_d      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_d = last_grant_q + IDX_W'(k);
      if (req[cand_d]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = cand_d;
      end
    end
  end

  assign send_last = SEND_W'(int'(len_q) * BITS_PER_FRAME * CLKS_PER_BIT - 1);

  // armed_q holds off granting for one edge after reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      armed_q      <= 1'b0;
      ack_q        <= '0;
      done_q       <= 1'b0;
      pulse_q      <= 1'b0;
      msg_q        <= '0;
      len_q        <= '0;
      send_cnt_q   <= '0;
      gap_cnt_q    <= '0;
    end else begin
      armed_q <= 1'b1;
      ack_q   <= '0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (armed_q && grant_vld_d) begin
            last_grant_q <= grant_idx_d;
            ack_q        <= NUM_REQ'(1) << grant_idx_d;
            msg_q        <= msg[MSG_W*grant_idx_d +: MSG_W];
            len_q        <= clamp_len(len[4*grant_idx_d +: 4]);
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          if (len_q == 4'd0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            pulse_q    <= 1'b1;
            send_cnt_q <= '0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (send_cnt_q == send_last) begin
            send_cnt_q <= '0;
            if (GAP_CYCLES == 0) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              gap_cnt_q <= '0;
              state_q   <= GAP;
            end
          end else begin
            send_cnt_q <= send_cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
            gap_cnt_q <= '0;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack  = ack_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

  uart_8bytes_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .bytes2send(msg_q),
    .bytes_num (len_q),
    .pulse     (pulse_q),
    .tx        (tx)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench: a transaction-level schedule model predicts ack/done cycles and the bytes seen on tx.
module tb_uart_tx_arbiter;

  localparam int C     = 4;
  localparam int GAPB  = 1;
  localparam int FRAME = 10 * C;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req   = '0;
  logic [255:0] msg   = '0;
  logic [15:0]  len   = '0;
  logic [3:0]   ack;
  logic         done;
  logic         busy;
  logic         tx;

  uart_tx_arbiter #(.CLKS_PER_BIT(C), .GAP_BITS(GAPB)) dut (
    .clk(clk), .reset(reset), .req(req), .msg(msg), .len(len),
    .ack(ack), .done(done), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  int   cyc      = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  typedef struct {
    int         cyc;
    logic [7:0] val;
    logic       ok;
  } ev_t;

  ev_t exp_ack[$], obs_ack[$], exp_rx[$], obs_rx[$];
  int  exp_done[$], obs_done[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
    else
      n_pass++;
  endtask

  // Monitor: logs ack/done events and decodes 8N1 frames from tx.
  ev_t        mon_e;
  logic       rx_busy = 1'b0;
  int         rx_start = 0;
  logic [9:0] rx_bits = '0;
  initial forever begin
    @(negedge clk);
    if (ack != 4'b0000) begin
      mon_e.cyc = cyc; mon_e.val = {4'b0000, ack}; mon_e.ok = 1'b1;
      obs_ack.push_back(mon_e);
    end
    if (done) obs_done.push_back(cyc);
    if (rst_seen) begin
      rx_busy = 1'b0;
    end else begin
      if (!rx_busy && tx == 1'b0) begin
        rx_busy  = 1'b1;
        rx_start = cyc;
      end
      if (rx_busy && ((cyc - rx_start) % C) == C / 2) begin
        rx_bits[(cyc - rx_start) / C] = tx;
        if ((cyc - rx_start) / C == 9) begin
          mon_e.cyc = rx_start; mon_e.val = rx_bits[8:1];
          mon_e.ok  = (rx_bits[0] == 1'b0) && (rx_bits[9] == 1'b1);
          obs_rx.push_back(mon_e);
          rx_busy = 1'b0;
        end
      end
    end
  end

  // Reference model state: pointer and first cycle in which the arbiter can sample req.
  int          m_lg   = 3;
  int          m_free = 0;
  logic [63:0] b_msg[4];
  int          b_len[4];
  int          w_bit = -1, w_on = -1, w_off = -1;

  function automatic int clamp8(input int l);
    return (l > 8) ? 8 : l;
  endfunction

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    repeat (ncyc) @(negedge clk);
    reset  = 1'b0;
    m_lg   = 3;
    m_free = cyc + 1;
  endtask

  task automatic load_inputs();
    for (int k = 0; k < 4; k++) begin
      msg[64*k +: 64] = b_msg[k];
      len[4*k +: 4]   = 4'(b_len[k]);
    end
  endtask

  task automatic compare_logs();
    check_eq("ack_count", 64'(obs_ack.size()), 64'(exp_ack.size()));
    for (int i = 0; i < obs_ack.size() && i < exp_ack.size(); i++) begin
      check_eq("ack_cycle", 64'(obs_ack[i].cyc), 64'(exp_ack[i].cyc));
      check_eq("ack_value", 64'(obs_ack[i].val), 64'(exp_ack[i].val));
    end
    check_eq("done_count", 64'(obs_done.size()), 64'(exp_done.size()));
    for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++)
      check_eq("done_cycle", 64'(obs_done[i]), 64'(exp_done[i]));
    check_eq("frame_count", 64'(obs_rx.size()), 64'(exp_rx.size()));
    for (int i = 0; i < obs_rx.size() && i < exp_rx.size(); i++) begin
      check_eq("frame_start", 64'(obs_rx[i].cyc), 64'(exp_rx[i].cyc));
      check_eq("frame_byte", 64'(obs_rx[i].val), 64'(exp_rx[i].val));
      check_eq("frame_8n1", 64'(obs_rx[i].ok), 64'(1));
    end
  endtask

  // Predicts the whole grant schedule for one batch, drives it, then compares logs.
  task automatic run_batch(input logic [3:0] mask, input bit hold, input int max_grants);
    int        s, n, g, lc, d, grants, lg, free, stop;
    int        drop[4];
    logic [3:0] pend;
    ev_t       e;
    exp_ack.delete(); exp_done.delete(); exp_rx.delete();
    obs_ack.delete(); obs_done.delete(); obs_rx.delete();
    s = cyc; free = m_free; lg = m_lg; pend = mask; grants = 0;
    for (int k = 0; k < 4; k++) drop[k] = -1;
    while (pend != 4'b0000 && grants < max_grants) begin
      n = (s > free) ? s : free;
      g = -1;
      for (int k = 1; k <= 4; k++)
        if (g < 0 && pend[(lg + k) % 4]) g = (lg + k) % 4;
      lc = clamp8(b_len[g]);
      e.cyc = n + 1; e.val = 8'(1 << g); e.ok = 1'b1;
      exp_ack.push_back(e);
      d = (lc == 0) ? n + 2 : n + 2 + lc * FRAME + GAPB * C;
      exp_done.push_back(d);
      for (int j = 0; j < lc; j++) begin
        e.cyc = n + 3 + j * FRAME; e.val = b_msg[g][8*j +: 8]; e.ok = 1'b1;
        exp_rx.push_back(e);
      end
      lg = g; grants++; free = d;
      if (!hold) begin
        pend[g] = 1'b0;
        drop[g] = n + 1;
      end else if (grants == max_grants) begin
        for (int k = 0; k < 4; k++) drop[k] = n + 1;
      end
    end
    load_inputs();
    req  = mask;
    stop = free + 3;
    while (cyc < stop) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (drop[k] == cyc) req[k] = 1'b0;
      if (w_bit >= 0 && cyc == w_on)  req[w_bit] = 1'b1;
      if (w_bit >= 0 && cyc == w_off) req[w_bit] = 1'b0;
      foreach (exp_ack[i])  if (cyc == exp_ack[i].cyc) check_eq("busy_in_load", 64'(busy), 64'(1));
      foreach (exp_done[i]) if (cyc == exp_done[i])    check_eq("busy_at_done", 64'(busy), 64'(0));
    end
    req    = '0;
    m_lg   = lg;
    m_free = free;
    compare_logs();
    $display("batch mask=%b hold=%0d grants=%0d end_cycle=%0d", mask, hold, grants, cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int   s_ab, n_ab;
  logic [3:0] rmask;

  initial begin
    for (int k = 0; k < 4; k++) begin b_msg[k] = '0; b_len[k] = 0; end

    do_reset(1);
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_ack",  64'(ack),  64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_tx",   64'(tx),   64'(1));

    // All four requesting from the release cycle: rotation 0,1,2,3,0.
    for (int k = 0; k < 4; k++) begin b_len[k] = 1; b_msg[k] = {$urandom, $urandom}; end
    run_batch(4'b1111, 1'b1, 5);

    b_msg[0] = {16'h0000, 40'haaaaaaaaaa, 8'h0a};
    b_len[0] = 2;
    run_batch(4'b0001, 1'b0, 4);

    // Requester 1 raised and dropped while the arbiter is in SEND.
    w_bit = 1; w_on = cyc + 10; w_off = cyc + 30;
    b_len[1] = 3;
    run_batch(4'b0001, 1'b0, 4);
    w_bit = -1;

    b_len[3] = 0;
    run_batch(4'b1000, 1'b0, 4);
    b_msg[2] = "ABCDEFG\n";
    b_len[2] = 15;
    run_batch(4'b0100, 1'b0, 4);

    // Abort requester 1 twenty cycles into SEND.
    b_len[1] = 2; b_msg[1] = {$urandom, $urandom};
    load_inputs();
    s_ab = cyc;
    n_ab = (s_ab > m_free) ? s_ab : m_free;
    req  = 4'b0010;
    while (cyc < n_ab + 1) @(negedge clk);
    check_eq("abort_ack", 64'(ack), 64'(4'b0010));
    req = '0;
    while (cyc < n_ab + 2 + 20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    m_lg   = 3;
    m_free = cyc + 1;
    check_eq("abort_busy", 64'(busy), 64'(0));
    check_eq("abort_done", 64'(done), 64'(0));
    check_eq("abort_tx",   64'(tx),   64'(1));
    b_len[2] = 1 + int'($urandom_range(0, 2)); b_msg[2] = {$urandom, $urandom};
    run_batch(4'b0100, 1'b0, 4);

    for (int t = 0; t < 8; t++) begin
      rmask = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) begin
        b_msg[k] = {$urandom, $urandom};
        b_len[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      end
      run_batch(rmask, (t % 4) == 3, 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
